// File: rtl/rbt_s_hdr_rr_arbiter.sv
// Round-robin arbiter feeding one transport-layer parser from PORTS proto-header streams.
// Optional per-port grant counters are built when RBT_S_HDR_ARB_STATS_EN is defined.
module rbt_s_hdr_rr_arbiter #(
  parameter int PORTS              = 4,
  parameter int HEADER_WIDTH       = 2048,
  parameter int PKT_METADATA_WIDTH = 272,
  parameter int SRC_W              = $clog2(PORTS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PORTS-1:0]                    cfg_port_en,
  input  logic [PORTS-1:0]                    in_hdr_valid,
  output logic [PORTS-1:0]                    in_hdr_ready,
  input  logic [PORTS*16-1:0]                 in_hdr_length,
  input  logic [PORTS*HEADER_WIDTH-1:0]       in_hdr_data,
  input  logic [PORTS*PKT_METADATA_WIDTH-1:0] in_hdr_pkt_metadata,
  output logic                                out_hdr_valid,
  input  logic                                out_hdr_ready,
  output logic [15:0]                         out_hdr_length,
  output logic [HEADER_WIDTH-1:0]             out_hdr_data,
  output logic [PKT_METADATA_WIDTH-1:0]       out_hdr_pkt_metadata,
  output logic [SRC_W-1:0]                    out_hdr_src,
`ifdef RBT_S_HDR_ARB_STATS_EN
  input  logic                                stat_clr,
  output logic [PORTS*32-1:0]                 stat_grant_cnt,
`endif
  output logic                                busy
);

  generate
    if (HEADER_WIDTH % 8 != 0) begin : g_bad_header_width
      $error("HEADER_WIDTH (%0d) must be a multiple of 8", HEADER_WIDTH);
    end
  endgenerate

  logic                          r_out_valid;
  logic [15:0]                   r_out_length;
  logic [HEADER_WIDTH-1:0]       r_out_data;
  logic [PKT_METADATA_WIDTH-1:0] r_out_meta;
  logic [SRC_W-1:0]              r_out_src;
  logic [SRC_W-1:0]              r_last_grant;

  logic [PORTS-1:0] w_req;
  logic [PORTS-1:0] w_ready;
  logic             w_load_en;
  logic             w_grant_found;
  logic [SRC_W-1:0] w_grant_idx;
  logic             w_xfer;

  assign w_req     = in_hdr_valid & cfg_port_en;
  assign w_load_en = !r_out_valid || out_hdr_ready;
  assign w_xfer    = !rst && w_load_en && w_grant_found;

  // Walk the ports starting just after the last winner, wrapping at PORTS-1.
  always_comb begin
    logic [SRC_W-1:0] v_cand;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    v_cand        = r_last_grant;
    for (int k = 0; k < PORTS; k++) begin
      v_cand = (v_cand == SRC_W'(PORTS - 1)) ? '0 : v_cand + SRC_W'(1);
      if (!w_grant_found && w_req[v_cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = v_cand;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_xfer) w_ready[w_grant_idx] = 1'b1;
  end

  assign in_hdr_ready = w_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_length <= '0;
      r_out_data   <= '0;
      r_out_meta   <= '0;
      r_out_src    <= '0;
      r_last_grant <= SRC_W'(PORTS - 1);
    end else if (w_xfer) begin
      r_out_valid  <= 1'b1;
      r_out_length <= in_hdr_length[w_grant_idx*16 +: 16];
      r_out_data   <= in_hdr_data[w_grant_idx*HEADER_WIDTH +: HEADER_WIDTH];
      r_out_meta   <= in_hdr_pkt_metadata[w_grant_idx*PKT_METADATA_WIDTH +: PKT_METADATA_WIDTH];
      r_out_src    <= w_grant_idx;
      r_last_grant <= w_grant_idx;
    end else if (out_hdr_ready) begin
      // Payload keeps its last value; only the valid flag drops.
      r_out_valid  <= 1'b0;
    end
  end

  assign out_hdr_valid        = r_out_valid;
  assign out_hdr_length       = r_out_length;
  assign out_hdr_data         = r_out_data;
  assign out_hdr_pkt_metadata = r_out_meta;
  assign out_hdr_src          = r_out_src;
  assign busy                 = r_out_valid || (|w_req);

`ifdef RBT_S_HDR_ARB_STATS_EN
  logic [PORTS-1:0][31:0] r_stat_cnt;

  // Clear has priority over a same-cycle grant; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      r_stat_cnt <= '0;
    end else if (w_xfer) begin
      r_stat_cnt[w_grant_idx] <= r_stat_cnt[w_grant_idx] + 32'd1;
    end
  end

  assign stat_grant_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_rbt_s_hdr_rr_arbiter.sv
// Self-checking bench for rbt_s_hdr_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level round-robin model.
module tb_rbt_s_hdr_rr_arbiter;
  localparam int PORTS = 4;
  localparam int HW    = 64;
  localparam int MW    = 24;
  localparam int SW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [PORTS-1:0]      cfg_port_en;
  logic [PORTS-1:0]      in_hdr_valid;
  logic [PORTS-1:0]      in_hdr_ready;
  logic [PORTS*16-1:0]   in_hdr_length;
  logic [PORTS*HW-1:0]   in_hdr_data;
  logic [PORTS*MW-1:0]   in_hdr_pkt_metadata;
  logic                  out_hdr_valid;
  logic                  out_hdr_ready;
  logic [15:0]           out_hdr_length;
  logic [HW-1:0]         out_hdr_data;
  logic [MW-1:0]         out_hdr_pkt_metadata;
  logic [SW-1:0]         out_hdr_src;
  logic                  busy;
`ifdef RBT_S_HDR_ARB_STATS_EN
  logic                  stat_clr;
  logic [PORTS*32-1:0]   stat_grant_cnt;
`endif

  rbt_s_hdr_rr_arbiter #(
    .PORTS(PORTS), .HEADER_WIDTH(HW), .PKT_METADATA_WIDTH(MW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_port_en(cfg_port_en),
    .in_hdr_valid(in_hdr_valid), .in_hdr_ready(in_hdr_ready),
    .in_hdr_length(in_hdr_length), .in_hdr_data(in_hdr_data),
    .in_hdr_pkt_metadata(in_hdr_pkt_metadata),
    .out_hdr_valid(out_hdr_valid), .out_hdr_ready(out_hdr_ready),
    .out_hdr_length(out_hdr_length), .out_hdr_data(out_hdr_data),
    .out_hdr_pkt_metadata(out_hdr_pkt_metadata), .out_hdr_src(out_hdr_src),
`ifdef RBT_S_HDR_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_grant_cnt(stat_grant_cnt),
`endif
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one output slot plus the index of the last port served.
  int               ptr;
  bit               m_valid;
  logic [15:0]      m_len;
  logic [HW-1:0]    m_data;
  logic [MW-1:0]    m_meta;
  int               m_src;
  int unsigned      m_cnt [PORTS];
  int               acc;
  logic [PORTS-1:0] obs_rdy;

  function automatic int pick(input logic [PORTS-1:0] req);
    for (int k = 1; k <= PORTS; k++) begin
      if (req[(ptr + k) % PORTS]) return (ptr + k) % PORTS;
    end
    return -1;
  endfunction

  task automatic set_port(input int i, input bit v);
    in_hdr_valid[i]                  = v;
    in_hdr_length[i*16 +: 16]        = 16'($urandom);
    in_hdr_data[i*HW +: HW]          = {$urandom, $urandom};
    in_hdr_pkt_metadata[i*MW +: MW]  = 24'($urandom);
  endtask

  // New header on a port only once the previous one was taken (upstream holds until ready).
  task automatic refresh_ports(input int prob);
    for (int i = 0; i < PORTS; i++) begin
      if (!in_hdr_valid[i] || acc == i) set_port(i, $urandom_range(99) < prob);
    end
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic cycle();
    logic [PORTS-1:0] req, exp_rdy;
    int g;
    bit load;
    bit clr;
    #1;
    req  = in_hdr_valid & cfg_port_en;
    g    = pick(req);
    load = !m_valid || out_hdr_ready;
    exp_rdy = '0;
    if (!rst && load && g >= 0) exp_rdy[g] = 1'b1;
    obs_rdy = in_hdr_ready;
    check("in_hdr_ready", in_hdr_ready, exp_rdy);
    check("busy", busy, m_valid || (req != 0));
    clr = 1'b0;
`ifdef RBT_S_HDR_ARB_STATS_EN
    clr = stat_clr;
`endif
    @(posedge clk);
    acc = -1;
    if (rst) begin
      m_valid = 0; m_len = '0; m_data = '0; m_meta = '0; m_src = 0; ptr = PORTS - 1;
    end else if (exp_rdy != 0) begin
      acc     = g;
      m_valid = 1;
      m_len   = in_hdr_length[g*16 +: 16];
      m_data  = in_hdr_data[g*HW +: HW];
      m_meta  = in_hdr_pkt_metadata[g*MW +: MW];
      m_src   = g;
      ptr     = g;
    end else if (out_hdr_ready) begin
      m_valid = 0;
    end
    if (rst || clr) begin
      for (int i = 0; i < PORTS; i++) m_cnt[i] = 0;
    end else if (acc >= 0) begin
      m_cnt[acc] = m_cnt[acc] + 1;
    end
    #1;
    check("out_hdr_valid", out_hdr_valid, m_valid);
    check("out_hdr_length", out_hdr_length, m_len);
    check("out_hdr_data", out_hdr_data, m_data);
    check("out_hdr_meta", out_hdr_pkt_metadata, m_meta);
    check("out_hdr_src", out_hdr_src, m_src);
`ifdef RBT_S_HDR_ARB_STATS_EN
    for (int i = 0; i < PORTS; i++) check("stat_cnt", stat_grant_cnt[i*32 +: 32], m_cnt[i]);
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_hdr_valid = '0;
    cfg_port_en = '1;
    out_hdr_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  int order [$];

  initial begin
    rst = 1'b1; cfg_port_en = '1; in_hdr_valid = '0; out_hdr_ready = 1'b1;
    in_hdr_length = '0; in_hdr_data = '0; in_hdr_pkt_metadata = '0;
`ifdef RBT_S_HDR_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    ptr = PORTS - 1; m_valid = 0; m_len = '0; m_data = '0; m_meta = '0; m_src = 0; acc = -1;
    for (int i = 0; i < PORTS; i++) m_cnt[i] = 0;
    @(negedge clk);

    // Reset, then a single request on port 2.
    do_reset();
    check("rst_out_valid", out_hdr_valid, 1'b0);
    check("rst_out_src", out_hdr_src, '0);
    set_port(2, 1'b1);
    in_hdr_length[2*16 +: 16] = 16'h0040;
    cycle();
    check("single_ready", obs_rdy, 4'b0100);
    check("single_src", out_hdr_src, 2);
    check("single_len", out_hdr_length, 16'h0040);
    in_hdr_valid = '0;
    cycle();

    // All ports requesting: strict rotation from port 0.
    do_reset();
    order.delete();
    for (int i = 0; i < PORTS; i++) set_port(i, 1'b1);
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("rr_valid", out_hdr_valid, 1'b1);
      order.push_back(int'(out_hdr_src));
      refresh_ports(100);
    end
    for (int c = 0; c < 6; c++) check("rr_order", order[c], c % PORTS);

    // Backpressure: port 1 fills the slot, then stall for 5 cycles.
    do_reset();
    out_hdr_ready = 1'b0;
    set_port(1, 1'b1);
    set_port(3, 1'b1);
    cycle();
    in_hdr_valid[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("bp_ready", obs_rdy, 4'b0000);
      check("bp_src", out_hdr_src, 1);
      check("bp_valid", out_hdr_valid, 1'b1);
    end
    out_hdr_ready = 1'b1;
    cycle();
    check("bp_release_src", out_hdr_src, 3);
    in_hdr_valid = '0;
    cycle();

    // Port mask 1011: port 2 skipped.
    do_reset();
    cfg_port_en = 4'b1011;
    order.delete();
    for (int i = 0; i < PORTS; i++) set_port(i, 1'b1);
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("mask_no_p2", obs_rdy[2], 1'b0);
      order.push_back(int'(out_hdr_src));
      refresh_ports(100);
    end
    check("mask_order0", order[0], 0);
    check("mask_order1", order[1], 1);
    check("mask_order2", order[2], 3);
    check("mask_order3", order[3], 0);

    // Reset while a header is stalled in the output register.
    do_reset();
    in_hdr_valid = '0;
    out_hdr_ready = 1'b0;
    set_port(1, 1'b1);
    cycle();
    in_hdr_valid[1] = 1'b0;
    cycle();
    check("pre_rst_valid", out_hdr_valid, 1'b1);
    rst = 1'b1;
    cycle();
    check("mid_rst_valid", out_hdr_valid, 1'b0);
    rst = 1'b0;
    out_hdr_ready = 1'b1;
    for (int i = 0; i < PORTS; i++) set_port(i, 1'b1);
    cycle();
    check("post_rst_ready", obs_rdy, 4'b0001);
    check("post_rst_src", out_hdr_src, 0);
    in_hdr_valid = '0;
    cycle();

`ifdef RBT_S_HDR_ARB_STATS_EN
    // Grant counters: count, clear-wins, wrap.
    do_reset();
    set_port(0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      cycle();
      set_port(0, 1'b1);
    end
    check("stat_ten", stat_grant_cnt[31:0], 32'd10);
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    check("stat_clr_wins", stat_grant_cnt[31:0], 32'd0);
    in_hdr_valid = '0;
    force dut.r_stat_cnt = {96'd0, 32'hFFFF_FFFF};
    #1;
    release dut.r_stat_cnt;
    m_cnt[0] = 32'hFFFF_FFFF;
    for (int i = 1; i < PORTS; i++) m_cnt[i] = 0;
    set_port(0, 1'b1);
    cycle();
    check("stat_wrap", stat_grant_cnt[31:0], 32'd0);
    in_hdr_valid = '0;
    cycle();
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(49) == 0) cfg_port_en = PORTS'($urandom);
      out_hdr_ready = ($urandom_range(99) < 70);
      rst = ($urandom_range(199) == 0);
`ifdef RBT_S_HDR_ARB_STATS_EN
      stat_clr = ($urandom_range(99) == 0);
`endif
      refresh_ports(50);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
